// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 64-bit unsigned multiply/divide sequencer that borrows the execute-stage ALU adder,
// running one shift-add (multiply) or restoring-subtract (divide) step per clock.
module alu_muldiv_seq (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] result_o,
   output logic        dbz_o,
   output logic [63:0] alu_a_o,
   output logic [63:0] alu_b_o,
   output logic        alu_cflag_o,
   output logic        alu_sum_en_o,
   output logic        alu_invB_en_o,
   input  logic [63:0] alu_out_i,
   input  logic        alu_cflag_i
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] p_q, p_d;
   logic [63:0] q_q, q_d;
   logic [63:0] m_q, m_d;
   logic [63:0] result_q, result_d;
   logic [1:0]  op_q, op_d;
   logic [5:0]  count_q, count_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;
   logic [63:0] shift_rem;
   logic        shift_out;

   // Divide step works on the 65-bit remainder {shift_out, shift_rem} without a wider adder.
   assign shift_rem = {p_q[62:0], q_q[63]};
   assign shift_out = p_q[63];

   always_comb begin
      alu_a_o       = '0;
      alu_b_o       = '0;
      alu_cflag_o   = 1'b0;
      alu_sum_en_o  = 1'b0;
      alu_invB_en_o = 1'b0;
      if (state_q == RUN) begin
         alu_sum_en_o = 1'b1;
         alu_b_o      = m_q;
         if (op_q[1]) begin
            alu_a_o       = shift_rem;
            alu_invB_en_o = 1'b1;
            alu_cflag_o   = 1'b1;
         end else begin
            alu_a_o = p_q;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      q_d      = q_q;
      m_d      = m_q;
      op_d     = op_q;
      count_d  = count_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               p_d     = '0;
               q_d     = a_i;
               m_d     = b_i;
               op_d    = op_i;
               count_d = '0;
               if (op_i[1] && (b_i == 64'd0)) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  dbz_d    = 1'b1;
                  result_d = op_i[0] ? a_i : '1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (op_q[1]) begin
               if (shift_out || alu_cflag_i) begin
                  p_d = alu_out_i;
                  q_d = {q_q[62:0], 1'b1};
               end else begin
                  p_d = shift_rem;
                  q_d = {q_q[62:0], 1'b0};
               end
            end else if (q_q[0]) begin
               p_d = {alu_cflag_i, alu_out_i[63:1]};
               q_d = {alu_out_i[0], q_q[63:1]};
            end else begin
               p_d = {1'b0, p_q[63:1]};
               q_d = {p_q[0], q_q[63:1]};
            end
            count_d = count_q + 6'd1;
            if (count_q == 6'd63) begin
               state_d  = DONE;
               done_d   = 1'b1;
               dbz_d    = 1'b0;
               result_d = op_q[0] ? p_d : q_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         p_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         op_q     <= '0;
         count_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         q_q      <= q_d;
         m_q      <= m_d;
         op_q     <= op_d;
         count_q  <= count_d;
         result_q <= result_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;
   assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: models the shared ALU adder, applies directed vectors,
// random operations against a plain-arithmetic reference, held-start and mid-run reset sequences.
module tb_alu_muldiv_seq;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'd0;
   logic [63:0] a_i = '0;
   logic [63:0] b_i = '0;
   logic        busy_o, done_o, dbz_o;
   logic [63:0] result_o, alu_a_o, alu_b_o, alu_out_i;
   logic        alu_cflag_o, alu_sum_en_o, alu_invB_en_o, alu_cflag_i;
   logic [64:0] alu_sum;

   int errors = 0;
   int checks = 0;

   alu_muldiv_seq dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .dbz_o(dbz_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_cflag_o(alu_cflag_o), .alu_sum_en_o(alu_sum_en_o),
      .alu_invB_en_o(alu_invB_en_o), .alu_out_i(alu_out_i), .alu_cflag_i(alu_cflag_i)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in for the execute-stage ALU adder path (other ALU functions are held off while busy).
   always_comb begin
      alu_sum = '0;
      if (alu_sum_en_o)
         alu_sum = {1'b0, alu_a_o} + {1'b0, (alu_invB_en_o ? ~alu_b_o : alu_b_o)} + {64'd0, alu_cflag_o};
   end
   assign alu_out_i   = alu_sum[63:0];
   assign alu_cflag_i = alu_sum[64];

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   // Returns {dbz, result} straight from unsigned arithmetic.
   function automatic logic [64:0] refModel(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] prod;
      prod = {64'd0, a} * {64'd0, b};
      case (op)
         2'd0:    return {1'b0, prod[63:0]};
         2'd1:    return {1'b0, prod[127:64]};
         2'd2:    return (b == 64'd0) ? {1'b1, 64'hFFFF_FFFF_FFFF_FFFF} : {1'b0, a / b};
         default: return (b == 64'd0) ? {1'b1, a} : {1'b0, a % b};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Issues one op from IDLE (called at a negedge) and waits, bounded, for its done pulse.
   task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic dbz, output int edges,
                                output logic alu_zero, output logic pulse_ok);
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      edges   = 0;
      while (!done_o && edges < 100) begin
         @(posedge clk_i);
         edges++;
         @(negedge clk_i);
      end
      res      = result_o;
      dbz      = dbz_o;
      alu_zero = (alu_a_o == 64'd0) && (alu_b_o == 64'd0) && !alu_cflag_o && !alu_sum_en_o && !alu_invB_en_o;
      @(negedge clk_i);
      pulse_ok = !done_o && !busy_o;
   endtask

   task automatic runAndCheck(input string tag, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] res;
      logic        dbz, alu_zero, pulse_ok;
      logic [64:0] exp;
      int          edges;
      exp = refModel(op, a, b);
      applyStimulus(op, a, b, res, dbz, edges, alu_zero, pulse_ok);
      checkOutput({tag, " latency"}, 64'(edges), exp[64] ? 64'd0 : 64'd64);
      checkOutput({tag, " result"}, res, exp[63:0]);
      checkOutput({tag, " dbz"}, {63'd0, dbz}, {63'd0, exp[64]});
      checkOutput({tag, " alu idle in done"}, {63'd0, alu_zero}, 64'd1);
      checkOutput({tag, " single done pulse"}, {63'd0, pulse_ok}, 64'd1);
   endtask

   initial begin
      logic [63:0] ha[0:139];
      logic [63:0] hb[0:139];
      logic [64:0] exp;
      logic [63:0] first_res;
      logic [63:0] ra, rb;
      logic [1:0]  rop;
      int          done_edges[$];
      int          unstable;
      int          dones;
      int          busy_seen;
      int          n;

      vecs[0] = '{2'd0, 64'd3, 64'd5, 64'd15, 1'b0};
      vecs[1] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
      vecs[2] = '{2'd1, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1'b0};
      vecs[3] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[4] = '{2'd2, 64'd100, 64'd7, 64'd14, 1'b0};
      vecs[5] = '{2'd3, 64'd100, 64'd7, 64'd2, 1'b0};
      vecs[6] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 1'b0};
      vecs[7] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[8] = '{2'd2, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[9] = '{2'd3, 64'd1234, 64'd0, 64'd1234, 1'b1};

      repeat (2) @(negedge clk_i);
      checkOutput("reset busy", {63'd0, busy_o}, 64'd0);
      checkOutput("reset done", {63'd0, done_o}, 64'd0);
      checkOutput("reset dbz", {63'd0, dbz_o}, 64'd0);
      checkOutput("reset result", result_o, 64'd0);
      checkOutput("reset alu_a", alu_a_o, 64'd0);
      checkOutput("reset alu_b", alu_b_o, 64'd0);
      checkOutput("reset alu ctl", {61'd0, alu_cflag_o, alu_sum_en_o, alu_invB_en_o}, 64'd0);
      reset_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 10; i++) begin
         logic [63:0] res;
         logic        dbz, alu_zero, pulse_ok;
         int          edges;
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, dbz, edges, alu_zero, pulse_ok);
         checkOutput($sformatf("vec%0d latency", i), 64'(edges), vecs[i].dbz ? 64'd0 : 64'd64);
         checkOutput($sformatf("vec%0d result", i), res, vecs[i].res);
         checkOutput($sformatf("vec%0d dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
         checkOutput($sformatf("vec%0d alu idle in done", i), {63'd0, alu_zero}, 64'd1);
         checkOutput($sformatf("vec%0d single done pulse", i), {63'd0, pulse_ok}, 64'd1);
      end

      for (int i = 0; i < 16; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 7) == 0) rb = 64'd0;
         runAndCheck($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
      end

      // start_i held high: DONE ignores it, so the second accept lands on the edge after IDLE returns.
      start_i = 1'b1;
      op_i    = 2'd0;
      unstable = 0;
      first_res = '0;
      for (int k = 0; k < 140; k++) begin
         ha[k] = {$urandom, $urandom};
         hb[k] = {$urandom, $urandom};
         a_i   = ha[k];
         b_i   = hb[k];
         @(posedge clk_i);
         @(negedge clk_i);
         if (done_o) done_edges.push_back(k);
         if (k == 64) first_res = result_o;
         if (k > 64 && k < 130 && result_o !== first_res) unstable++;
         if (k == 65) checkOutput("held busy low after done", {63'd0, busy_o}, 64'd0);
         if (k == 130) begin
            exp = refModel(2'd0, ha[66], hb[66]);
            checkOutput("held second result", result_o, exp[63:0]);
         end
      end
      start_i = 1'b0;
      exp = refModel(2'd0, ha[0], hb[0]);
      checkOutput("held first result", first_res, exp[63:0]);
      checkOutput("held done count", 64'(done_edges.size()), 64'd2);
      checkOutput("held first done edge", (done_edges.size() > 0) ? 64'(done_edges[0]) : 64'hDEAD, 64'd64);
      checkOutput("held second done edge", (done_edges.size() > 1) ? 64'(done_edges[1]) : 64'hDEAD, 64'd130);
      checkOutput("held result stable", 64'(unstable), 64'd0);
      n = 0;
      while (busy_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("held drain idle", {63'd0, busy_o}, 64'd0);
      @(negedge clk_i);

      // Reset around cycle 30 of a multiply abandons it silently.
      start_i = 1'b1;
      op_i    = 2'd0;
      a_i     = 64'd3;
      b_i     = 64'd5;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (29) @(negedge clk_i);
      checkOutput("pre-reset busy", {63'd0, busy_o}, 64'd1);
      reset_i = 1'b0;
      #1;
      checkOutput("mid-run reset busy", {63'd0, busy_o}, 64'd0);
      checkOutput("mid-run reset result", result_o, 64'd0);
      checkOutput("mid-run reset done", {63'd0, done_o}, 64'd0);
      @(negedge clk_i);
      reset_i = 1'b1;
      dones = 0;
      busy_seen = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk_i);
         if (done_o) dones++;
         if (busy_o) busy_seen++;
      end
      checkOutput("no done after reset", 64'(dones), 64'd0);
      checkOutput("stays idle after reset", 64'(busy_seen), 64'd0);
      runAndCheck("post-reset mul", 2'd0, 64'd12345, 64'd678);
      runAndCheck("post-reset mulhu", 2'd1, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
